// File: rtl/sspis_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sspis_ctl_if
//  Purpose  : SPI pins plus 32-bit register-bus signals of the SPI responder.
//             The slave modport is the responder's view; master is the
//             view of the SPI master / register file around it.
//  Revision : 1.0  initial release
// ============================================================================
interface sspis_ctl_if;
  logic        cfg_endian;
  logic        spi_sclk;
  logic        spi_ssn;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [3:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        frame_done;

  modport slave (
    input  cfg_endian, spi_sclk, spi_ssn, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wr, reg_wdata, reg_be,
           reg_rd, frame_done
  );

  modport master (
    output cfg_endian, spi_sclk, spi_ssn, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wr, reg_wdata, reg_be,
           reg_rd, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/sspis_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : sspis_ctl
//  Purpose  : SPI mode-0 responder. Oversamples sclk/ssn/mosi in the clk
//             domain, decodes a command byte {rw,rsvd,size[1:0],addr[3:0]}
//             and turns each frame into one 32-bit register write or read.
//  Options  : SSPIS_STATUS_EN - shift a status byte
//             {4'b1010, frame_cnt[2:0], abort_flag} out on MISO during CMD.
//  Revision : 1.0  initial release
// ============================================================================
module sspis_ctl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  sspis_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Synchroniser chains; ssn idles high so reset produces no false edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, ssn_dly_q;

  logic sclk_s, ssn_s, mosi_s;
  logic sclk_rise, sclk_fall, ssn_rise, ssn_fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wacc_q, wacc_d;
  logic [3:0]  beacc_q, beacc_d;
  logic        reg_wr_q, reg_wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        reg_rd_q, reg_rd_d;
  logic        rd_lat_q, rd_lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        miso_q, miso_d;
  logic        frame_done_q, frame_done_d;
`ifdef SSPIS_STATUS_EN
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic        abort_q, abort_d;
  logic [7:0]  stat_q, stat_d;
`endif

  logic [7:0]  byte_in;
  logic [1:0]  lane;
  logic [7:0]  rd_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ssn_rise  = ssn_s & ~ssn_dly_q;
  assign ssn_fall  = ~ssn_s & ssn_dly_q;

  // Byte being completed on this rise, and the lane the current byte maps to.
  assign byte_in = {shift_q[6:0], mosi_s};
  assign lane    = bus.cfg_endian ? (2'd3 - byte_cnt_q) : byte_cnt_q;
  assign rd_byte = rdata_q[{lane, 3'b000} +: 8];

  // Bring the asynchronous SPI pins into the clk domain and keep a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ssn_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], bus.spi_ssn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_dly_q  <= sclk_s;
      ssn_dly_q   <= ssn_s;
    end
  end

  // Frame FSM, shift/assembly datapath and register-bus strobes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wacc_d       = wacc_q;
    beacc_d      = beacc_q;
    reg_wr_d     = 1'b0;
    wdata_d      = wdata_q;
    be_d         = be_q;
    reg_rd_d     = 1'b0;
    rd_lat_d     = reg_rd_q;
    rdata_d      = rdata_q;
    miso_d       = miso_q;
    frame_done_d = 1'b0;
`ifdef SSPIS_STATUS_EN
    frame_cnt_d  = frame_cnt_q;
    abort_d      = abort_q;
    stat_d       = stat_q;
`endif

    // Read data returns on the bus one clk after the strobe.
    if (rd_lat_q) rdata_d = bus.reg_rdata;

    if (ssn_rise) begin
      // End of frame from any state: only a fully received frame counts.
      state_d      = ST_IDLE;
      bit_cnt_d    = 3'd0;
      byte_cnt_d   = 2'd0;
      shift_d      = 8'd0;
      wacc_d       = 32'd0;
      beacc_d      = 4'd0;
      miso_d       = 1'b0;
      frame_done_d = (state_q == ST_DRAIN);
`ifdef SSPIS_STATUS_EN
      if (state_q == ST_DRAIN) frame_cnt_d = frame_cnt_q + 3'd1;
      if ((state_q == ST_CMD) || (state_q == ST_DATA)) abort_d = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ssn_fall) begin
            state_d    = ST_CMD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            shift_d    = 8'd0;
            wacc_d     = 32'd0;
            beacc_d    = 4'd0;
`ifdef SSPIS_STATUS_EN
            // Snapshot the status so the mid-byte flag clear cannot corrupt it.
            stat_d = {4'b1010, frame_cnt_q, abort_q};
            miso_d = stat_d[7];
`else
            miso_d = 1'b0;
`endif
          end
        end

        ST_CMD: begin
`ifdef SSPIS_STATUS_EN
          if (sclk_fall) miso_d = stat_q[~bit_cnt_q];
`endif
          if (sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d       = byte_in[7];
              size_d     = byte_in[5:4];
              addr_d     = byte_in[3:0];
              reg_rd_d   = byte_in[7];
              byte_cnt_d = 2'd0;
              miso_d     = 1'b0;
              state_d    = ST_DATA;
`ifdef SSPIS_STATUS_EN
              abort_d = 1'b0;
`endif
            end
          end
        end

        ST_DATA: begin
          // Falls drive read data MSB first; bit index is 7-bit_cnt.
          if (sclk_fall && rw_q) miso_d = rd_byte[~bit_cnt_q];
          if (sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rw_q) begin
                wacc_d[{lane, 3'b000} +: 8] = byte_in;
                beacc_d[lane]               = 1'b1;
              end
              if (byte_cnt_q == size_q) begin
                state_d = ST_DRAIN;
                miso_d  = 1'b0;
                if (!rw_q) begin
                  reg_wr_d = 1'b1;
                  wdata_d  = wacc_d;
                  be_d     = beacc_d;
                end
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
          end
        end

        ST_DRAIN: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 8'd0;
      rw_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 4'd0;
      wacc_q       <= 32'd0;
      beacc_q      <= 4'd0;
      reg_wr_q     <= 1'b0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      reg_rd_q     <= 1'b0;
      rd_lat_q     <= 1'b0;
      rdata_q      <= 32'd0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SSPIS_STATUS_EN
      frame_cnt_q  <= 3'd0;
      abort_q      <= 1'b0;
      stat_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wacc_q       <= wacc_d;
      beacc_q      <= beacc_d;
      reg_wr_q     <= reg_wr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      reg_rd_q     <= reg_rd_d;
      rd_lat_q     <= rd_lat_d;
      rdata_q      <= rdata_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
`ifdef SSPIS_STATUS_EN
      frame_cnt_q  <= frame_cnt_d;
      abort_q      <= abort_d;
      stat_q       <= stat_d;
`endif
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = ~ssn_s;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_be      = be_q;
  assign bus.reg_rd      = reg_rd_q;
  assign bus.frame_done  = frame_done_q;

endmodule
`default_nettype wire
